// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue-side handshake, op decode and response capture
// for the 32-bit ALU. Optional overflow trap: ALU_ISSUE_OVF_TRAP_EN.
module alu_issue_ctrl #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_aluop,
  input  logic [5:0]        req_funct,
  input  logic [DWIDTH-1:0] req_a,
  input  logic [DWIDTH-1:0] req_b,
  output logic [3:0]        alu_op,
  output logic [DWIDTH-1:0] alu_rs1,
  output logic [DWIDTH-1:0] alu_rs2,
  input  logic [DWIDTH-1:0] alu_rd,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data,
  output logic              res_zero,
  output logic              res_ovf,
  output logic              res_err,
  output logic [CWIDTH-1:0] ops_cnt,
  output logic [CWIDTH-1:0] err_cnt,
  output logic              trap,
  input  logic              trap_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_NONE = 4'b1111;
  localparam logic [CWIDTH-1:0] CNT_ONE = 1;

  state_e state_q, state_d;

  logic [3:0]        op_q;
  logic [DWIDTH-1:0] a_q, b_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              rzero_q, rovf_q, rerr_q;
  logic [CWIDTH-1:0] ops_q, err_q;
  logic              trap_q;

  logic       dec_legal;
  logic [3:0] dec_op;
  logic       accept;
  logic       done;

  // Translate ALUOp/funct into the ALU operation code.
  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OP_NONE;
    unique case (req_aluop)
      2'b00: dec_op = 4'b0010;
      2'b01: dec_op = 4'b0110;
      2'b10: begin
        case (req_funct)
          6'b100000: dec_op = 4'b0010;
          6'b100010: dec_op = 4'b0110;
          6'b100100: dec_op = 4'b0000;
          6'b100101: dec_op = 4'b0001;
          6'b100111: dec_op = 4'b1100;
          6'b101010: dec_op = 4'b0111;
          6'b101100: dec_op = 4'b0011;
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign done   = (state_q == RESP) && res_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = dec_legal ? EXEC : RESP;
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and ALU-drive outputs; ALU sees its idle code outside EXEC.
  always_comb begin
    req_ready = (state_q == IDLE) && !trap_q;
    res_valid = (state_q == RESP);
    alu_op    = OP_NONE;
    alu_rs1   = '0;
    alu_rs2   = '0;
    if (state_q == EXEC) begin
      alu_op  = op_q;
      alu_rs1 = a_q;
      alu_rs2 = b_q;
    end
  end

  // Latch request operands and capture the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      rzero_q <= 1'b0;
      rovf_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else if (accept) begin
      if (dec_legal) begin
        op_q <= dec_op;
        a_q  <= req_a;
        b_q  <= req_b;
      end else begin
        rdata_q <= '0;
        rzero_q <= 1'b0;
        rovf_q  <= 1'b0;
        rerr_q  <= 1'b1;
      end
    end else if (state_q == EXEC) begin
      rdata_q <= alu_rd;
      rzero_q <= alu_zero;
      rovf_q  <= alu_ovf;
      rerr_q  <= 1'b0;
    end
  end

  // Saturating completion counters, stepped on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q <= '0;
      err_q <= '0;
    end else if (done) begin
      if (rerr_q) begin
        if (err_q != '1) err_q <= err_q + CNT_ONE;
      end else begin
        if (ops_q != '1) ops_q <= ops_q + CNT_ONE;
      end
    end
  end

`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic trap_set;
  assign trap_set = (state_q == EXEC) && alu_ovf &&
                    ((op_q == 4'b0010) || (op_q == 4'b0110));

  // Sticky overflow trap; a set on the same edge beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        trap_q <= 1'b0;
    else if (trap_set) trap_q <= 1'b1;
    else if (trap_clr) trap_q <= 1'b0;
  end
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap_q = 1'b0;
`endif

  assign res_data = rdata_q;
  assign res_zero = rzero_q;
  assign res_ovf  = rovf_q;
  assign res_err  = rerr_q;
  assign ops_cnt  = ops_q;
  assign err_cnt  = err_q;
  assign trap     = trap_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed + random transactions against a
// behavioural reference; small counter width to reach saturation.
module tb_alu_issue_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_aluop;
  logic [5:0]    req_funct;
  logic [DW-1:0] req_a, req_b;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_rs1, alu_rs2, alu_rd;
  logic          alu_zero, alu_ovf;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic          res_zero, res_ovf, res_err;
  logic [CW-1:0] ops_cnt, err_cnt;
  logic          trap, trap_clr;

  int total = 0;
  int bad = 0;
  int m_ops = 0;
  int m_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_rd(alu_rd), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero),
    .res_ovf(res_ovf), .res_err(res_err),
    .ops_cnt(ops_cnt), .err_cnt(err_cnt),
    .trap(trap), .trap_clr(trap_clr)
  );

  // Combinational ALU standing in for the real datapath.
  always_comb begin
    case (alu_op)
      4'b0010: alu_rd = alu_rs1 + alu_rs2;
      4'b0110: alu_rd = alu_rs1 - alu_rs2;
      4'b0000: alu_rd = alu_rs1 & alu_rs2;
      4'b0001: alu_rd = alu_rs1 | alu_rs2;
      4'b1100: alu_rd = ~(alu_rs1 | alu_rs2);
      4'b0111: alu_rd = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
      4'b0011: alu_rd = alu_rs1 ^ alu_rs2;
      default: alu_rd = '0;
    endcase
    alu_zero = (alu_rd == '0);
    case (alu_op)
      4'b0010: alu_ovf = (alu_rs1[31] == alu_rs2[31]) &&
                         (alu_rd[31] != alu_rs1[31]);
      4'b0110: alu_ovf = (alu_rs1[31] != alu_rs2[31]) &&
                         (alu_rd[31] != alu_rs1[31]);
      default: alu_ovf = 1'b0;
    endcase
  end

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Reference: what the instruction means, in wide signed arithmetic.
  task automatic ref_model(
    input  logic [1:0]    op,
    input  logic [5:0]    fn,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          legal,
    output logic [3:0]    eop,
    output logic [DW-1:0] er,
    output logic          ez,
    output logic          eo
  );
    longint sa, sb, wide;
    int kind;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    kind = -1;
    if (op == 2'b00) kind = 0;
    else if (op == 2'b01) kind = 1;
    else if (op == 2'b10) begin
      if (fn == 6'd32) kind = 0;
      else if (fn == 6'd34) kind = 1;
      else if (fn == 6'd36) kind = 2;
      else if (fn == 6'd37) kind = 3;
      else if (fn == 6'd39) kind = 4;
      else if (fn == 6'd42) kind = 5;
      else if (fn == 6'd44) kind = 6;
    end
    legal = (kind >= 0);
    eop = 4'b1111;
    er = '0;
    eo = 1'b0;
    wide = 0;
    case (kind)
      0: begin eop = 4'd2;  wide = sa + sb; end
      1: begin eop = 4'd6;  wide = sa - sb; end
      2: begin eop = 4'd0;  er = a & b; end
      3: begin eop = 4'd1;  er = a | b; end
      4: begin eop = 4'd12; er = ~(a | b); end
      5: begin eop = 4'd7;  er = (sa < sb) ? 1 : 0; end
      6: begin eop = 4'd3;  er = a ^ b; end
      default: ;
    endcase
    if (kind == 0 || kind == 1) begin
      er = wide[DW-1:0];
      eo = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    end
    ez = legal && (er == '0);
  endtask

  task automatic run_txn(
    input string         nm,
    input logic [1:0]    op,
    input logic [5:0]    fn,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input int            hold
  );
    logic legal, ez, eo, etrap;
    logic [3:0] eop;
    logic [DW-1:0] er;
    int n;
    ref_model(op, fn, a, b, legal, eop, er, ez, eo);
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_wait got=%b want=1", nm, req_ready);
      return;
    end
    req_valid = 1'b1;
    req_aluop = op;
    req_funct = fn;
    req_a = a;
    req_b = b;
    res_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    if (legal) begin
      total++;
      if ({alu_op, alu_rs1, alu_rs2, res_valid, req_ready} !==
          {eop, a, b, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL %s exec got op=%b rs1=%h rs2=%h v=%b r=%b want op=%b rs1=%h rs2=%h v=0 r=0",
                 nm, alu_op, alu_rs1, alu_rs2, res_valid, req_ready, eop, a, b);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i <= hold; i++) begin
      total++;
      if ({res_valid, req_ready, alu_op, res_data, res_zero, res_ovf, res_err} !==
          {1'b1, 1'b0, 4'b1111, er, ez, eo, !legal}) begin
        bad++;
        $display("FAIL %s resp[%0d] got v=%b r=%b op=%b d=%h z=%b o=%b e=%b want v=1 r=0 op=1111 d=%h z=%b o=%b e=%b",
                 nm, i, res_valid, req_ready, alu_op, res_data, res_zero,
                 res_ovf, res_err, er, ez, eo, !legal);
      end
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (legal) m_ops++;
    else m_err++;
    etrap = TRAP_EN && legal && eo && (eop == 4'd2 || eop == 4'd6);
    total++;
    if ({res_valid, int'(ops_cnt), int'(err_cnt), trap, req_ready} !==
        {1'b0, sat(m_ops), sat(m_err), etrap, !etrap}) begin
      bad++;
      $display("FAIL %s done got v=%b ops=%0d err=%0d trap=%b r=%b want v=0 ops=%0d err=%0d trap=%b r=%b",
               nm, res_valid, ops_cnt, err_cnt, trap, req_ready,
               sat(m_ops), sat(m_err), etrap, !etrap);
    end
    if (trap) begin
      trap_clr = 1'b1;
      @(posedge clk); #1;
      trap_clr = 1'b0;
      total++;
      if ({trap, req_ready} !== 2'b01) begin
        bad++;
        $display("FAIL %s trap_clr got trap=%b r=%b want trap=0 r=1",
                 nm, trap, req_ready);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_aluop = '0;
    req_funct = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    trap_clr = 1'b0;
    #12;
    total++;
    if ({req_ready, res_valid, res_data, res_zero, res_ovf, res_err,
         alu_op, alu_rs1, alu_rs2, ops_cnt, err_cnt, trap} !==
        {1'b1, 1'b0, 32'h0, 3'b000, 4'b1111, 64'h0, 8'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset got r=%b v=%b d=%h op=%b ops=%0d err=%0d trap=%b want r=1 v=0 d=0 op=1111 ops=0 err=0 trap=0",
               req_ready, res_valid, res_data, alu_op, ops_cnt, err_cnt, trap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ops = 0;
    m_err = 0;
  endtask

  task automatic test_directed;
    run_txn("add_rtype", 2'b10, 6'b100000, 32'd5, 32'd7, 0);
    run_txn("sub_zero", 2'b01, 6'b000000, 32'h1234, 32'h1234, 0);
    run_txn("add_ovf", 2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1, 0);
    run_txn("illegal_funct", 2'b10, 6'b111111, 32'hDEAD, 32'hBEEF, 0);
    run_txn("illegal_aluop", 2'b11, 6'b100000, 32'h1, 32'h2, 1);
  endtask

  task automatic test_backpressure;
    run_txn("slt_hold", 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 5);
    run_txn("nor_hold", 2'b10, 6'b100111, 32'h0F0F0000, 32'h00F0, 3);
  endtask

  task automatic test_random;
    logic [5:0] fl [7];
    logic [5:0] fn;
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd44};
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
      else fn = fl[$urandom_range(0, 6)];
      run_txn("random", 2'($urandom), fn, $urandom, $urandom,
              $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_aluop = 2'b00;
    req_a = 32'd3;
    req_b = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (alu_op !== 4'b0010) begin
      bad++;
      $display("FAIL rst_mid_exec got op=%b want 0010", alu_op);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, res_valid, res_data, res_err, alu_op, alu_rs1,
         ops_cnt, err_cnt, trap} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 4'b1111, 32'h0, 8'h0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid got r=%b v=%b d=%h op=%b ops=%0d err=%0d want r=1 v=0 d=0 op=1111 ops=0 err=0",
               req_ready, res_valid, res_data, alu_op, ops_cnt, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ops = 0;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({res_valid, req_ready, alu_op} !== {1'b0, 1'b1, 4'b1111}) begin
      bad++;
      $display("FAIL rst_mid_after got v=%b r=%b op=%b want v=0 r=1 op=1111",
               res_valid, req_ready, alu_op);
    end
    run_txn("post_reset", 2'b10, 6'b100101, 32'hA0, 32'h0B, 0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
